// File: rtl/voice_alloc_pkg.sv
// Shared types and constants for the voice allocator: FSM states, commit actions, note width.
package voice_alloc_pkg;

    localparam int NOTE_BITS = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_GAP    = 2'd2,
        ST_COMMIT = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        ACT_NONE = 2'd0,
        ACT_ON   = 2'd1,
        ACT_OFF  = 2'd2,
        ACT_DROP = 2'd3
    } act_e;

endpackage

// File: rtl/voice_slot.sv
// One voice slot: note, gate and saturating age registers with load / clear / age-increment commands.
module voice_slot
    import voice_alloc_pkg::*;
#(
    parameter int AGE_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_i,
    input  logic                 clr_i,
    input  logic                 age_inc_i,
    input  logic [NOTE_BITS-1:0] note_i,
    output logic [NOTE_BITS-1:0] note_o,
    output logic                 gate_o,
    output logic [AGE_BITS-1:0]  age_o
);

    logic [NOTE_BITS-1:0] note_q, note_d;
    logic                 gate_q, gate_d;
    logic [AGE_BITS-1:0]  age_q, age_d;

    // Ungated slots ignore age increments so their age stays frozen.
    always_comb begin
        note_d = note_q;
        gate_d = gate_q;
        age_d  = age_q;
        if (load_i) begin
            note_d = note_i;
            gate_d = 1'b1;
            age_d  = '0;
        end else if (clr_i) begin
            gate_d = 1'b0;
        end else if (age_inc_i && gate_q && (age_q != '1)) begin
            age_d = age_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            note_q <= '0;
            gate_q <= 1'b0;
            age_q  <= '0;
        end else begin
            note_q <= note_d;
            gate_q <= gate_d;
            age_q  <= age_d;
        end
    end

    assign note_o = note_q;
    assign gate_o = gate_q;
    assign age_o  = age_q;

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: sequential slot scan, retrigger gap, commit. Full-pool note-ons steal
// the oldest voice when VOICE_STEAL_EN is defined, otherwise they are dropped with a pulse.
module voice_allocator
    import voice_alloc_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int AGE_BITS   = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            ev_valid,
    output logic                            ev_ready,
    input  logic                            ev_note_on,
    input  logic [NOTE_BITS-1:0]            ev_note,
    output logic [NUM_VOICES*NOTE_BITS-1:0] voice_note,
    output logic [NUM_VOICES-1:0]           voice_gate,
    output logic                            dropped,
    output state_e                          dbg_state,
    output logic [NUM_VOICES*AGE_BITS-1:0]  dbg_age
);

    localparam int IDX_W = $clog2(NUM_VOICES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

    // Handshake: an event transfers on a rising edge where ev_valid && ev_ready; ev_ready is high
    // only in IDLE, so the offered fields are latched exactly once per accepted event.
    state_e               state_q, state_d;
    act_e                 act_q, act_d;
    logic [IDX_W-1:0]     scan_idx_q, scan_idx_d;
    logic                 ev_on_q, ev_on_d;
    logic [NOTE_BITS-1:0] ev_note_q, ev_note_d;
    logic                 match_vld_q, match_vld_d;
    logic [IDX_W-1:0]     match_idx_q, match_idx_d;
    logic                 free_vld_q, free_vld_d;
    logic [IDX_W-1:0]     free_idx_q, free_idx_d;
    logic                 old_vld_q, old_vld_d;
    logic [IDX_W-1:0]     old_idx_q, old_idx_d;
    logic [AGE_BITS-1:0]  old_age_q, old_age_d;
    logic [IDX_W-1:0]     tgt_idx_q, tgt_idx_d;
    logic                 gap_req;

    logic [NOTE_BITS-1:0]            slot_note [NUM_VOICES];
    logic [AGE_BITS-1:0]             slot_age  [NUM_VOICES];
    logic [NUM_VOICES-1:0]           gate_w;
    logic [NUM_VOICES*NOTE_BITS-1:0] note_w;
    logic [NUM_VOICES*AGE_BITS-1:0]  age_w;
    logic [NUM_VOICES-1:0]           load_w, clr_w, inc_w;

    logic                 cur_gate;
    logic [NOTE_BITS-1:0] cur_note;
    logic [AGE_BITS-1:0]  cur_age;

    assign cur_gate = gate_w[scan_idx_q];
    assign cur_note = slot_note[scan_idx_q];
    assign cur_age  = slot_age[scan_idx_q];

    always_comb begin
        state_d     = state_q;
        act_d       = act_q;
        scan_idx_d  = scan_idx_q;
        ev_on_d     = ev_on_q;
        ev_note_d   = ev_note_q;
        match_vld_d = match_vld_q;
        match_idx_d = match_idx_q;
        free_vld_d  = free_vld_q;
        free_idx_d  = free_idx_q;
        old_vld_d   = old_vld_q;
        old_idx_d   = old_idx_q;
        old_age_d   = old_age_q;
        tgt_idx_d   = tgt_idx_q;
        gap_req     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ev_valid) begin
                    state_d     = ST_SCAN;
                    act_d       = ACT_NONE;
                    scan_idx_d  = '0;
                    ev_on_d     = ev_note_on;
                    ev_note_d   = ev_note;
                    match_vld_d = 1'b0;
                    free_vld_d  = 1'b0;
                    old_vld_d   = 1'b0;
                    old_age_d   = '0;
                end
            end
            ST_SCAN: begin
                if (cur_gate && (cur_note == ev_note_q) && !match_vld_q) begin
                    match_vld_d = 1'b1;
                    match_idx_d = scan_idx_q;
                end
                if (!cur_gate && !free_vld_q) begin
                    free_vld_d = 1'b1;
                    free_idx_d = scan_idx_q;
                end
                // Strict compare keeps the lowest index on equal ages.
                if (cur_gate && (!old_vld_q || (cur_age > old_age_q))) begin
                    old_vld_d = 1'b1;
                    old_idx_d = scan_idx_q;
                    old_age_d = cur_age;
                end
                if (scan_idx_q == LAST_IDX) begin
                    if (!ev_note_q[NOTE_BITS-1]) begin
                        if (ev_on_q) begin
                            if (match_vld_d) begin
                                tgt_idx_d = match_idx_d;
                                act_d     = ACT_ON;
                                gap_req   = 1'b1;
                            end else if (free_vld_d) begin
                                tgt_idx_d = free_idx_d;
                                act_d     = ACT_ON;
                            end else begin
                                tgt_idx_d = old_idx_d;
`ifdef VOICE_STEAL_EN
                                act_d     = ACT_ON;
                                gap_req   = 1'b1;
`else
                                act_d     = ACT_DROP;
`endif
                            end
                        end else if (match_vld_d) begin
                            tgt_idx_d = match_idx_d;
                            act_d     = ACT_OFF;
                        end
                    end
                    state_d = gap_req ? ST_GAP : ST_COMMIT;
                end else begin
                    scan_idx_d = scan_idx_q + 1'b1;
                end
            end
            ST_GAP:    state_d = ST_COMMIT;
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            act_q       <= ACT_NONE;
            scan_idx_q  <= '0;
            ev_on_q     <= 1'b0;
            ev_note_q   <= '0;
            match_vld_q <= 1'b0;
            match_idx_q <= '0;
            free_vld_q  <= 1'b0;
            free_idx_q  <= '0;
            old_vld_q   <= 1'b0;
            old_idx_q   <= '0;
            old_age_q   <= '0;
            tgt_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            act_q       <= act_d;
            scan_idx_q  <= scan_idx_d;
            ev_on_q     <= ev_on_d;
            ev_note_q   <= ev_note_d;
            match_vld_q <= match_vld_d;
            match_idx_q <= match_idx_d;
            free_vld_q  <= free_vld_d;
            free_idx_q  <= free_idx_d;
            old_vld_q   <= old_vld_d;
            old_idx_q   <= old_idx_d;
            old_age_q   <= old_age_d;
            tgt_idx_q   <= tgt_idx_d;
        end
    end

    // GAP clears the target gate for one cycle; COMMIT then reloads it.
    for (genvar i = 0; i < NUM_VOICES; i++) begin : g_slot
        logic is_tgt;
        assign is_tgt    = (tgt_idx_q == IDX_W'(i));
        assign load_w[i] = (state_q == ST_COMMIT) && (act_q == ACT_ON) && is_tgt;
        assign clr_w[i]  = ((state_q == ST_GAP) && is_tgt) ||
                           ((state_q == ST_COMMIT) && (act_q == ACT_OFF) && is_tgt);
        assign inc_w[i]  = (state_q == ST_COMMIT) && (act_q == ACT_ON) && !is_tgt;

        voice_slot #(
            .AGE_BITS (AGE_BITS)
        ) u_slot (
            .clk       (clk),
            .rst       (rst),
            .load_i    (load_w[i]),
            .clr_i     (clr_w[i]),
            .age_inc_i (inc_w[i]),
            .note_i    (ev_note_q),
            .note_o    (slot_note[i]),
            .gate_o    (gate_w[i]),
            .age_o     (slot_age[i])
        );

        assign note_w[i*NOTE_BITS +: NOTE_BITS] = slot_note[i];
        assign age_w[i*AGE_BITS +: AGE_BITS]    = slot_age[i];
    end

    assign ev_ready   = (state_q == ST_IDLE) && !rst;
    assign dropped    = (state_q == ST_COMMIT) && (act_q == ACT_DROP) && !rst;
    assign voice_gate = rst ? '0 : gate_w;
    assign voice_note = rst ? '0 : note_w;
    assign dbg_state  = state_q;
    assign dbg_age    = age_w;

endmodule
